// File: rtl/cluster_periph_demux_if.sv
// Master-side request/response bus of the cluster peripheral demux.
// The master modport is the requester; the slave modport is the demux.
interface cluster_periph_demux_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                   req;
    logic [AddrWidth-1:0]   add;
    logic                   we;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] be;
    logic                   gnt;
    logic                   r_valid;
    logic [DataWidth-1:0]   r_data;
    logic                   r_err;

    modport master (
        output req, add, we, data, be,
        input  gnt, r_valid, r_data, r_err
    );

    modport slave (
        input  req, add, we, data, be,
        output gnt, r_valid, r_data, r_err
    );
endinterface

// File: rtl/cluster_periph_demux.sv
// Address-decoding demux from one cluster master onto NumSlaves peripheral windows.
// Optional macro CLUSTER_PERIPH_DEMUX_ERR_RESP_EN adds an internal decode-error slave.
module cluster_periph_demux #(
    parameter int unsigned          NumSlaves      = 11,
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter int unsigned          WindowBits     = 10,
    parameter logic [AddrWidth-1:0] BaseAddr       = AddrWidth'(32'h1020_0000),
    parameter int unsigned          MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    cluster_periph_demux_if.slave                mst,
    output logic [NumSlaves-1:0]                 slv_req_o,
    output logic [AddrWidth-1:0]                 slv_add_o,
    output logic                                 slv_we_o,
    output logic [DataWidth-1:0]                 slv_data_o,
    output logic [DataWidth/8-1:0]               slv_be_o,
    input  logic [NumSlaves-1:0]                 slv_gnt_i,
    input  logic [NumSlaves-1:0]                 slv_r_valid_i,
    input  logic [NumSlaves-1:0][DataWidth-1:0]  slv_r_data_i
);

    localparam int unsigned IdxW = $clog2(NumSlaves + 1);
    localparam int unsigned CntW = 4;

`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
    localparam logic [IdxW-1:0] ErrIdx  = IdxW'(NumSlaves);
    localparam logic [31:0]     ErrWord = 32'hBADA_CCE5;

    function automatic logic [DataWidth-1:0] err_word();
        logic [DataWidth-1:0] w;
        w = '0;
        for (int i = 0; i < DataWidth && i < 32; i++) w[i] = ErrWord[i];
        return w;
    endfunction
`else
    localparam logic [IdxW-1:0] ErrIdx  = IdxW'(NumSlaves - 1);
`endif

    logic [AddrWidth-1:0] off, win;
    logic                 mapped;
    logic [IdxW-1:0]      idx;
    logic [CntW-1:0]      outst_q, outst_d;
    logic [IdxW-1:0]      last_tgt_q, last_tgt_d;
    logic                 stall, sel_gnt, grant;
    logic                 rsp_raw, rsp_vld;
    logic [DataWidth-1:0] rsp_data_raw;

    assign off    = mst.add - BaseAddr;
    assign win    = off >> WindowBits;
    assign mapped = (mst.add >= BaseAddr) && (win < AddrWidth'(NumSlaves));
    assign idx    = mapped ? win[IdxW-1:0] : ErrIdx;

    // Only one target may have traffic in flight, which keeps responses in grant order.
    assign stall = (outst_q == CntW'(MaxOutstanding)) ||
                   ((outst_q != '0) && (idx != last_tgt_q));

`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
    logic err_pend_q, err_pend_d;
`endif

    always_comb begin
        sel_gnt      = 1'b0;
        rsp_raw      = 1'b0;
        rsp_data_raw = '0;
        for (int i = 0; i < int'(NumSlaves); i++) begin
            if (idx == IdxW'(i)) sel_gnt = slv_gnt_i[i];
            if (last_tgt_q == IdxW'(i)) begin
                rsp_raw      = slv_r_valid_i[i];
                rsp_data_raw = slv_r_data_i[i];
            end
        end
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
        if (idx == ErrIdx) sel_gnt = 1'b1;
        if (last_tgt_q == ErrIdx) begin
            rsp_raw      = err_pend_q;
            rsp_data_raw = err_word();
        end
`endif
    end

    assign grant   = mst.req & ~stall & sel_gnt & ~rst_i;
    assign rsp_vld = rsp_raw & (outst_q != '0) & ~rst_i;

    always_comb begin
        slv_req_o = '0;
        for (int i = 0; i < int'(NumSlaves); i++)
            slv_req_o[i] = mst.req & ~stall & ~rst_i & (idx == IdxW'(i));
    end

    assign slv_add_o   = mst.add;
    assign slv_we_o    = mst.we;
    assign slv_data_o  = mst.data;
    assign slv_be_o    = mst.be;

    assign mst.gnt     = grant;
    assign mst.r_valid = rsp_vld;
    assign mst.r_data  = rsp_vld ? rsp_data_raw : '0;
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
    assign mst.r_err   = rsp_vld & (last_tgt_q == ErrIdx);
    assign err_pend_d  = grant & (idx == ErrIdx);
`else
    assign mst.r_err   = 1'b0;
`endif

    always_comb begin
        outst_d = outst_q;
        if (grant && !rsp_vld)      outst_d = outst_q + 1'b1;
        else if (rsp_vld && !grant) outst_d = outst_q - 1'b1;
        last_tgt_d = grant ? idx : last_tgt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst_q    <= '0;
            last_tgt_q <= '0;
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
            err_pend_q <= 1'b0;
`endif
        end else begin
            outst_q    <= outst_d;
            last_tgt_q <= last_tgt_d;
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
            err_pend_q <= err_pend_d;
`endif
        end
    end

endmodule
